// File: rtl/run_control_pkg.sv
// Shared definitions for the run controller: state encodings and default widths.
package run_control_pkg;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } run_state_t;

    localparam int PC_W_DEF  = 12;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/run_control_if.sv
// Debug/front-panel command bundle plus the controller's status outputs.
interface run_control_if
    import run_control_pkg::*;
#(
    parameter int PC_W  = PC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             cmd_run;
    logic             cmd_halt;
    logic             cmd_step;
    logic             cmd_clr;
    logic             p;
    logic [PC_W-1:0]  pc;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic             cpu_en;
    logic [1:0]       state;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output cmd_run, cmd_halt, cmd_step, cmd_clr, p, pc, bp_en, bp_addr,
        input  cpu_en, state, halted, bp_hit, instr_count
    );

    modport slave (
        input  cmd_run, cmd_halt, cmd_step, cmd_clr, p, pc, bp_en, bp_addr,
        output cpu_en, state, halted, bp_hit, instr_count
    );
endinterface

// File: rtl/run_control_instr_counter.sv
// Retired-instruction up-counter; clear takes priority over increment, wraps at all-ones.
module instr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/run_control.sv
// Execution controller: run/halt/step sequencing, PC breakpoint and retire counting
// by gating the shared clock-enable of the PC, phase flip-flop and flags.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_HALT  | stopped at a fetch boundary by command
// ST_RUN   | free running; halts at next boundary or breaks on pc match
// ST_STEP  | one fetch + one execute, then back to HALT
// ST_BREAK | stopped in front of the breakpoint instruction
module run_control
    import run_control_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter bit RUN_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    run_control_if.slave  bus
);

    run_state_t      state_q, state_d;
    logic            halt_pend_q, halt_pend_d;
    logic            skip_bp_q, skip_bp_d;
    logic            bp_hit_q, bp_hit_d;
    logic            bp_block;
    logic            cpu_en;
    logic            boundary;
    logic [PC_W-1:0] pc_cur;
    logic [PC_W-1:0] bp_cur;

    assign pc_cur = bus.pc;
    assign bp_cur = bus.bp_addr;

    // Blocking only on a fetch keeps HALT/BREAK entry aligned to p=0.
    assign bp_block = !bus.p && bus.bp_en && (pc_cur == bp_cur) && !skip_bp_q;
    assign cpu_en   = ((state_q == ST_RUN) && !bp_block) || (state_q == ST_STEP);
    assign boundary = bus.p && cpu_en;

    always_comb begin
        state_d     = state_q;
        halt_pend_d = halt_pend_q;
        skip_bp_d   = skip_bp_q;
        bp_hit_d    = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (bus.cmd_step) begin
                    state_d = ST_STEP;
                end else if (bus.cmd_run) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bp_block) begin
                    state_d     = ST_BREAK;
                    bp_hit_d    = 1'b1;
                    halt_pend_d = 1'b0;
                end else if (boundary && (halt_pend_q || bus.cmd_halt)) begin
                    state_d     = ST_HALT;
                    halt_pend_d = 1'b0;
                end else if (bus.cmd_halt) begin
                    halt_pend_d = 1'b1;
                end
                if (!bus.p && cpu_en) begin
                    skip_bp_d = 1'b0;
                end
            end
            ST_STEP: begin
                if (boundary) begin
                    state_d = ST_HALT;
                end
            end
            ST_BREAK: begin
                if (bus.cmd_halt) begin
                    state_d = ST_HALT;
                end else if (bus.cmd_step) begin
                    state_d = ST_STEP;
                end else if (bus.cmd_run) begin
                    // Let the instruction at bp_addr be fetched once before re-arming.
                    state_d   = ST_RUN;
                    skip_bp_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN_ON_RESET ? ST_RUN : ST_HALT;
            halt_pend_q <= 1'b0;
            skip_bp_q   <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_pend_q <= halt_pend_d;
            skip_bp_q   <= skip_bp_d;
            bp_hit_q    <= bp_hit_d;
        end
    end

    instr_counter #(
        .CNT_W (CNT_W)
    ) u_instr_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (boundary),
        .clr   (bus.cmd_clr),
        .count (bus.instr_count)
    );

    assign bus.cpu_en = cpu_en;
    assign bus.state  = state_q;
    assign bus.halted = (state_q == ST_HALT) || (state_q == ST_BREAK);
    assign bus.bp_hit = bp_hit_q;

endmodule

// File: tb/tb_run_control.sv
// Directed bench for run_control: a tiny phase/PC model follows cpu_en around an 8-word loop.
module tb_run_control;

    localparam int PC_W  = 12;
    localparam int CNT_W = 10;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    run_control_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    run_control #(
        .PC_W         (PC_W),
        .CNT_W        (CNT_W),
        .RUN_ON_RESET (1'b0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock; the phase flip-flop and PC advance when the pre-edge cpu_en was high.
    task automatic tick();
        logic en;
        logic rst;
        #2;
        en  = bus.cpu_en;
        rst = reset;
        @(posedge clk);
        #1;
        if (!rst) begin
            bus.p  = 1'b0;
            bus.pc = '0;
        end else if (en) begin
            if (bus.p) bus.pc = (bus.pc + 12'd1) & 12'h007;
            bus.p = ~bus.p;
        end
        #1;
    endtask

    task automatic pulse(input logic r, input logic h, input logic s, input logic c);
        bus.cmd_run  = r;
        bus.cmd_halt = h;
        bus.cmd_step = s;
        bus.cmd_clr  = c;
        tick();
        bus.cmd_run  = 1'b0;
        bus.cmd_halt = 1'b0;
        bus.cmd_step = 1'b0;
        bus.cmd_clr  = 1'b0;
    endtask

    task automatic do_step();
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        bus.cmd_run  = 1'b0;
        bus.cmd_halt = 1'b0;
        bus.cmd_step = 1'b0;
        bus.cmd_clr  = 1'b0;
        bus.p        = 1'b0;
        bus.pc       = '0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;
        repeat (3) tick();
        reset = 1'b1;
        tick();

        chk("rst_state",  32'(bus.state), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd1);
        chk("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        chk("rst_count",  32'(bus.instr_count), 32'd0);
        chk("rst_bp_hit", 32'(bus.bp_hit), 32'd0);

        // single step: enable on fetch and execute, then HALT with count 1
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("step_fetch_en",    32'(bus.cpu_en), 32'd1);
        chk("step_fetch_state", 32'(bus.state), 32'd2);
        tick();
        chk("step_exec_en", 32'(bus.cpu_en), 32'd1);
        chk("step_exec_p",  32'(bus.p), 32'd1);
        tick();
        chk("step_done_state", 32'(bus.state), 32'd0);
        chk("step_done_count", 32'(bus.instr_count), 32'd1);
        chk("step_done_en",    32'(bus.cpu_en), 32'd0);

        // breakpoint at 0x004, run from pc=1
        bus.bp_en   = 1'b1;
        bus.bp_addr = 12'h004;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_state", 32'(bus.state), 32'd1);
        repeat (6) tick();
        chk("bp_block_en",    32'(bus.cpu_en), 32'd0);
        chk("bp_block_count", 32'(bus.instr_count), 32'd4);
        tick();
        chk("bp_state",  32'(bus.state), 32'd3);
        chk("bp_hit_1",  32'(bus.bp_hit), 32'd1);
        chk("bp_halted", 32'(bus.halted), 32'd1);
        tick();
        chk("bp_hit_0",     32'(bus.bp_hit), 32'd0);
        chk("bp_state_hold", 32'(bus.state), 32'd3);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("resume_en", 32'(bus.cpu_en), 32'd1);
        tick();
        tick();
        chk("resume_retire", 32'(bus.instr_count), 32'd5);
        repeat (14) tick();
        chk("rehit_en",    32'(bus.cpu_en), 32'd0);
        chk("rehit_count", 32'(bus.instr_count), 32'd12);
        tick();
        chk("rehit_hit", 32'(bus.bp_hit), 32'd1);
        bus.bp_en = 1'b0;
        tick();
        chk("bp_en_off_stays", 32'(bus.state), 32'd3);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("break_halt", 32'(bus.state), 32'd0);

        // halt on a fetch cycle: the execute still completes
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("halt_fetch_exec", 32'(bus.state), 32'd1);
        tick();
        chk("halt_fetch_state", 32'(bus.state), 32'd0);
        chk("halt_fetch_count", 32'(bus.instr_count), 32'd13);

        // halt on an execute cycle
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("halt_exec_state", 32'(bus.state), 32'd0);
        chk("halt_exec_count", 32'(bus.instr_count), 32'd14);

        // all commands together
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        chk("combo_halt_state", 32'(bus.state), 32'd2);
        tick();
        tick();
        chk("combo_halt_count", 32'(bus.instr_count), 32'd15);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b1, 1'b1, 1'b0);
        chk("combo_run_state", 32'(bus.state), 32'd1);
        tick();
        chk("combo_run_halt",  32'(bus.state), 32'd0);
        chk("combo_run_count", 32'(bus.instr_count), 32'd16);

        // clear coincident with a boundary
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_boundary",  32'(bus.instr_count), 32'd0);
        chk("clr_run_state", 32'(bus.state), 32'd1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("clr_then_halt", 32'(bus.instr_count), 32'd1);
        chk("clr_halt_state", 32'(bus.state), 32'd0);

        // wrap: preload to all-ones with steps, one more wraps to zero
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_idle", 32'(bus.instr_count), 32'd0);
        for (int i = 0; i < (1 << CNT_W) - 1; i++) do_step();
        chk("count_max",  32'(bus.instr_count), 32'((1 << CNT_W) - 1));
        do_step();
        chk("count_wrap", 32'(bus.instr_count), 32'd0);

        // reset during the execute cycle of a step
        do_step();
        chk("pre_rst_count", 32'(bus.instr_count), 32'd1);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("pre_rst_exec", 32'(bus.p), 32'd1);
        reset = 1'b0;
        tick();
        chk("mid_rst_state",  32'(bus.state), 32'd0);
        chk("mid_rst_count",  32'(bus.instr_count), 32'd0);
        chk("mid_rst_bp_hit", 32'(bus.bp_hit), 32'd0);
        chk("mid_rst_en",     32'(bus.cpu_en), 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_state", 32'(bus.state), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/run_control.md
# run_control

Execution controller for the 4-bit microprocessor. It sequences the fetch/execute datapath by driving the common clock-enable of the program counter, phase flip-flop and flag register. It provides run, halt and single-step commands, a program-address breakpoint, and a retired-instruction counter. It sits between the debug/front-panel inputs and the `control_signals` / fetch logic, and replaces that block's hard-wired phase enable.

## Interface
Parameters:
- `PC_W`, 12, program-counter width (ROM address).
- `CNT_W`, 16, retired-instruction counter width.
- `RUN_ON_RESET`, 1, selects the state after reset: 1 = RUN, 0 = HALT.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `cmd_run`  in  1  one-cycle pulse: start or resume free running.
- `cmd_halt`  in  1  one-cycle pulse: stop at the next instruction boundary.
- `cmd_step`  in  1  one-cycle pulse: execute exactly one instruction.
- `cmd_clr`  in  1  one-cycle pulse: clear `instr_count`.
- `p`  in  1  current phase from the phase flip-flop: 0 = fetch, 1 = execute.
- `pc`  in  PC_W  current program-counter value.
- `bp_en`  in  1  breakpoint enable.
- `bp_addr`  in  PC_W  breakpoint address.
- `cpu_en`  out  1  enable for the PC, phase and flags; combinational.
- `state`  out  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK.
- `halted`  out  1  high in HALT or BREAK.
- `bp_hit`  out  1  registered one-cycle pulse on the first cycle of BREAK.
- `instr_count`  out  CNT_W  number of retired instructions.

## Operation
- Instruction boundary: a cycle with `p`=1 and `cpu_en`=1 (the execute cycle completes).
- Retire: `instr_count` increments on every boundary. It wraps from all-ones to 0. `cmd_clr` wins over a coincident increment (result is 0).
- `bp_block` = `p`=0 & `bp_en` & (`pc`==`bp_addr`) & !`skip_bp`.
- `cpu_en` = (state RUN & !`bp_block`) | state STEP. It is 0 in HALT and BREAK.
- Command priority when several commands are asserted together: halt > step > run.

State transitions:
- HALT:
  - `cmd_step` → STEP.
  - `cmd_run` → RUN.
  - `cmd_halt` is ignored.
- RUN:
  - `cmd_halt` sets `halt_pend`. On a boundary with `halt_pend` set (or with `cmd_halt` in that same cycle) → HALT, and `halt_pend` clears.
  - `bp_block` → BREAK in the next cycle. The fetch is suppressed in the blocking cycle.
  - `cmd_step` and `cmd_run` are ignored.
- STEP:
  - `cpu_en`=1 for the fetch cycle and the execute cycle. The breakpoint is ignored.
  - After the boundary → HALT.
  - `cmd_halt` has no effect because the step always completes.
- BREAK:
  - `cmd_run` → RUN and sets `skip_bp`.
  - `cmd_step` → STEP.
  - `cmd_halt` → HALT.
  - Deasserting `bp_en` does not leave BREAK.
- `skip_bp` clears after the first fetch cycle executed in RUN (`p`=0 & `cpu_en`).
- HALT and BREAK are only entered with `p`=0, so every resume starts on a fetch.

Reset (`reset`=0 at a rising edge):
- state ← RUN if `RUN_ON_RESET`, else HALT.
- `instr_count`, `bp_hit`, `halt_pend`, `skip_bp` ← 0.
- A reset during STEP or RUN abandons the instruction in progress without retiring it. The phase flip-flop resets in the same cycle.

## Timing
- Command sampled in cycle n → new state and `cpu_en` valid in cycle n+1.
- Step: `cmd_step` in cycle n → `cpu_en`=1 in n+1 (fetch) and n+2 (execute) → `state`=HALT and `instr_count`+1 visible in n+3.
- Halt: `cmd_halt` during a fetch cycle → that instruction's execute still occurs → HALT one cycle after the boundary. `cmd_halt` during an execute cycle → HALT in the next cycle.
- Breakpoint: `cpu_en` drops in the same cycle `pc` matches (combinational). `state`=BREAK and `bp_hit`=1 in the next cycle. The instruction at `bp_addr` has not been fetched.
- Resume from BREAK via `cmd_run`: the instruction at `bp_addr` executes, and a re-hit on the same address is possible only on a later fetch.
- `cpu_en` has a combinational path from `pc`, `p`, `bp_en` and `bp_addr`. The integrator must budget for this path.

## Structure
- Shared include file holds the state encodings (HALT/RUN/STEP/BREAK) and the default `PC_W` / `CNT_W`.
- One sub-module, `instr_counter`: a CNT_W up-counter with `inc`, `clr` and synchronous active-low reset.
- The FSM, `halt_pend`, `skip_bp`, the breakpoint comparator and `bp_hit` live in `run_control`.

## Test plan
- Reset with `RUN_ON_RESET`=0, then pulse `cmd_step` at cycle 5 → `cpu_en` high exactly at cycles 6 and 7; `state`=HALT and `instr_count`=1 at cycle 8.
- RUN with `bp_en`=1, `bp_addr`=0x004 → `cpu_en`=0 in the cycle `pc`=0x004 and `p`=0; `bp_hit` pulses once; `cmd_run` → the instruction at 0x004 retires; the breakpoint re-hits only on the next pass through 0x004.
- `cmd_halt` on a fetch cycle in RUN → one more boundary, then HALT. `cmd_halt` on an execute cycle → HALT on the next cycle. `instr_count` differs by exactly 1 between the two cases.
- Same-cycle `cmd_run` + `cmd_step` + `cmd_halt` in HALT → STEP. In RUN, the same combination → HALT at the next boundary.
- `instr_count` preloaded to 0xFFFF via 65535 steps, one more step → 0x0000. `cmd_clr` coincident with a boundary → 0x0000.
- `reset`=0 during the execute cycle of a STEP → state/count per `RUN_ON_RESET`, `instr_count`=0, `bp_hit`=0, `cpu_en` follows the reset state.
